// File: rtl/i2c_channel_sel_pkg.sv
// Shared types for the I2C demux channel selector: the select code and the switch FSM states.
// The FSM state is held in a 2-bit register.
package i2c_chsel_pkg;

    typedef logic [3:0] sel_t;

    localparam sel_t SEL_NONE = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IDLE,
        BREAK
    } chsel_state_e;

endpackage

// File: rtl/i2c_channel_sel_bus_monitor.sv
// I2C bus monitor: synchronises SCL/SDA, detects START/STOP, tracks bus_busy (START/STOP lag pins by SYNC_STAGES+1).
// No backpressure. I2C_CHSEL_IDLE_TIMEOUT_EN adds an idle timeout that clears a stuck bus_busy.
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic bus_busy,
    output logic start_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   bus_busy_q, bus_busy_d;
    logic                   scl_s, sda_s, stop_det;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign bus_busy  = bus_busy_q;

`ifdef I2C_CHSEL_IDLE_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        sda_prev_d = sda_s;
        bus_busy_d = bus_busy_q;
        if (start_det) begin
            bus_busy_d = 1'b1;
        end else if (stop_det) begin
            bus_busy_d = 1'b0;
        end
`ifdef I2C_CHSEL_IDLE_TIMEOUT_EN
        // Counter saturates so a long-idle bus keeps bus_busy clear; a START needs SDA low, which resets it.
        idle_cnt_d = '0;
        if (scl_s && sda_s) begin
            if (idle_cnt_q == IW'(IDLE_CYCLES - 1)) begin
                idle_cnt_d = idle_cnt_q;
                bus_busy_d = 1'b0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            sda_prev_q <= 1'b1;
            bus_busy_q <= 1'b0;
`ifdef I2C_CHSEL_IDLE_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            sda_prev_q <= sda_prev_d;
            bus_busy_q <= bus_busy_d;
`ifdef I2C_CHSEL_IDLE_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
`endif
        end
    end

endmodule

// File: rtl/i2c_channel_sel.sv
// Break-before-make channel selector for an 8-way I2C demux; switches only while the bus is idle.
// Idle-bus latency: select=0 at accept+2, new code at accept+2+SETTLE_CYCLES; req_ready low while a switch is pending.
module i2c_channel_sel
    import i2c_chsel_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int IDLE_CYCLES   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_ch,
    output logic       req_ready,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic [3:0] select,
    output logic       bus_busy,
    output logic       switch_done,
    output logic       req_err
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    chsel_state_e     state_q, state_d;
    sel_t             select_q, select_d;
    sel_t             ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             start_det;

    i2c_bus_monitor #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_bus_monitor (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .bus_busy  (bus_busy),
        .start_det (start_det)
    );

    assign req_ready   = (state_q == IDLE);
    assign select      = select_q;
    assign switch_done = done_q;
    assign req_err     = err_q;

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_ch > sel_t'(NUM_CH)) begin
                        err_d = 1'b1;
                    end else if (req_ch == select_q) begin
                        done_d = 1'b1;
                    end else begin
                        ch_d    = req_ch;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (!bus_busy && !start_det) begin
                    select_d = SEL_NONE;
                    cnt_d    = '0;
                    state_d  = BREAK;
                end
            end
            BREAK: begin
                // A new transaction during settle restarts the whole break; select is already 0.
                if (start_det) begin
                    state_d = WAIT_IDLE;
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    select_d = ch_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            select_q <= SEL_NONE;
            ch_q     <= SEL_NONE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_i2c_channel_sel.sv
// Self-checking bench for i2c_channel_sel: pulse scoreboard plus per-scenario timing checks.
// Honours I2C_CHSEL_IDLE_TIMEOUT_EN to pick the expected idle-timeout behaviour.
module tb_i2c_channel_sel;

    localparam int SETTLE = 16;
    localparam int IDLE_CYC = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_ch;
    logic       req_ready;
    logic       scl_in;
    logic       sda_in;
    logic [3:0] select;
    logic       bus_busy;
    logic       switch_done;
    logic       req_err;

    typedef struct {
        logic       is_err;
        logic [3:0] sel;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] cur_sel = 4'd0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    i2c_channel_sel #(
        .NUM_CH        (8),
        .SYNC_STAGES   (2),
        .SETTLE_CYCLES (SETTLE),
        .IDLE_CYCLES   (IDLE_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ch      (req_ch),
        .req_ready   (req_ready),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .select      (select),
        .bus_busy    (bus_busy),
        .switch_done (switch_done),
        .req_err     (req_err)
    );

    // Scoreboard: every done/err pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset && (switch_done || req_err)) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: done=%b err=%b select=%0d, required no pulse",
                             switch_done, req_err, select);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (req_err !== mon_e.is_err || switch_done !== !mon_e.is_err || select !== mon_e.sel) begin
                        n_err++;
                        $display("FAIL sb_pulse: done=%b err=%b select=%0d, required done=%b err=%b select=%0d",
                                 switch_done, req_err, select, !mon_e.is_err, mon_e.is_err, mon_e.sel);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents a request at a negedge; returns at the negedge after the accepting posedge (accept+1).
    task automatic do_req(input logic [3:0] ch);
        int   k;
        exp_t e;
        k = 0;
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_timeout: req_ready=%b, required 1", req_ready);
        end
        e.is_err = (ch > 4'd8);
        e.sel    = e.is_err ? cur_sel : ch;
        exp_q.push_back(e);
        if (!e.is_err) cur_sel = ch;
        req_valid = 1'b1;
        req_ch    = ch;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (switch_done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (switch_done !== 1'b1) begin
            n_err++;
            $display("FAIL done_timeout: switch_done=%b select=%0d, required pulse within %0d cycles",
                     switch_done, select, limit);
        end
    endtask

    task automatic bus_start();
        scl_in = 1'b1;
        sda_in = 1'b0;
        tick(4);
        scl_in = 1'b0;
        tick(2);
    endtask

    task automatic bus_stop();
        scl_in = 1'b0;
        sda_in = 1'b0;
        tick(2);
        scl_in = 1'b1;
        tick(2);
        sda_in = 1'b1;
        tick(4);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_ch    = 4'd0;
        scl_in    = 1'b1;
        sda_in    = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        n_vec++;
        if (select !== 4'd0) begin
            n_err++;
            $display("FAIL reset_select: select=%0d, required 0", select);
        end
        n_vec++;
        if ({req_ready, bus_busy, switch_done, req_err} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_flags: ready/busy/done/err=%b, required 1000",
                     {req_ready, bus_busy, switch_done, req_err});
        end
        mon_en = 1'b1;
    endtask

    task automatic test_switch(input logic [3:0] ch);
        logic [3:0] old;
        old = cur_sel;
        do_req(ch);
        n_vec++;
        if (select !== old) begin
            n_err++;
            $display("FAIL sw_hold_acc1: select=%0d, required %0d", select, old);
        end
        tick(1);
        n_vec++;
        if (select !== 4'd0) begin
            n_err++;
            $display("FAIL sw_break_acc2: select=%0d, required 0", select);
        end
        tick(SETTLE - 1);
        n_vec++;
        if (select !== 4'd0 || switch_done !== 1'b0) begin
            n_err++;
            $display("FAIL sw_settle_end: select=%0d done=%b, required 0 0", select, switch_done);
        end
        tick(1);
        n_vec++;
        if (select !== ch || switch_done !== 1'b1) begin
            n_err++;
            $display("FAIL sw_make: select=%0d done=%b, required %0d 1", select, switch_done, ch);
        end
    endtask

    task automatic test_busy_hold();
        logic [3:0] old;
        int         k;
        old = cur_sel;
        bus_start();
        n_vec++;
        if (bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_set: bus_busy=%b, required 1", bus_busy);
        end
        do_req(4'd7);
        tick(30);
        n_vec++;
        if (select !== old || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_hold: select=%0d busy=%b, required %0d 1", select, bus_busy, old);
        end
        bus_stop();
        k = 0;
        while (select !== 4'd0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (select !== 4'd0 || bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_break_after_stop: select=%0d busy=%b, required 0 0", select, bus_busy);
        end
        wait_done(40);
        n_vec++;
        if (select !== 4'd7) begin
            n_err++;
            $display("FAIL busy_final: select=%0d, required 7", select);
        end
    endtask

    task automatic test_start_in_break();
        do_req(4'd5);
        tick(4);
        bus_start();
        tick(4);
        n_vec++;
        if (select !== 4'd0 || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL brk_start: select=%0d busy=%b, required 0 1", select, bus_busy);
        end
        tick(20);
        n_vec++;
        if (select !== 4'd0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL brk_wait: select=%0d ready=%b, required 0 0", select, req_ready);
        end
        bus_stop();
        wait_done(60);
        n_vec++;
        if (select !== 4'd5) begin
            n_err++;
            $display("FAIL brk_final: select=%0d, required 5", select);
        end
    endtask

    task automatic test_reject_and_same();
        logic [3:0] held;
        bit         glitch;
        held = cur_sel;
        do_req(4'd9);
        n_vec++;
        if (req_err !== 1'b1 || select !== held || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rej9: err=%b select=%0d ready=%b, required 1 %0d 1", req_err, select, req_ready, held);
        end
        tick(1);
        do_req(4'd15);
        n_vec++;
        if (req_err !== 1'b1 || select !== held) begin
            n_err++;
            $display("FAIL rej15: err=%b select=%0d, required 1 %0d", req_err, select, held);
        end
        tick(1);
        do_req(held);
        n_vec++;
        if (switch_done !== 1'b1 || select !== held) begin
            n_err++;
            $display("FAIL same_done: done=%b select=%0d, required 1 %0d", switch_done, select, held);
        end
        glitch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (select !== held) glitch = 1'b1;
            tick(1);
        end
        n_vec++;
        if (glitch !== 1'b0) begin
            n_err++;
            $display("FAIL same_noglitch: select left %0d, required steady", held);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] old;
        old = cur_sel;
        bus_start();
        sda_in = 1'b1;
        tick(2);
        scl_in = 1'b1;
        do_req(4'd4);
`ifdef I2C_CHSEL_IDLE_TIMEOUT_EN
        wait_done(200);
        n_vec++;
        if (select !== 4'd4 || bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_clear: select=%0d busy=%b, required 4 0", select, bus_busy);
        end
`else
        tick(150);
        n_vec++;
        if (select !== old || bus_busy !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_none: select=%0d busy=%b, required %0d 1", select, bus_busy, old);
        end
        reset = 1'b1;
        tick(2);
        exp_q.delete();
        cur_sel = 4'd0;
        reset   = 1'b0;
        tick(1);
        n_vec++;
        if (select !== 4'd0 || req_ready !== 1'b1 || bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_drop: select=%0d ready=%b busy=%b, required 0 1 0", select, req_ready, bus_busy);
        end
        tick(30);
`endif
    endtask

    task automatic test_back_to_back();
        test_switch(4'd1);
        test_switch(4'd2);
    endtask

    initial begin
        test_reset();
        test_switch(4'd3);
        test_switch(4'd8);
        test_busy_hold();
        test_start_in_break();
        test_reject_and_same();
        test_switch(4'd0);
        test_timeout();
        test_back_to_back();
        tick(5);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
